// File: rtl/scope_capture.sv
// scope_capture: multi-channel trigger-and-capture engine with a circular
// pre-trigger buffer and trigger-relative readout of the frozen frame.
module scope_capture #(
    parameter int NUM_CH       = 2,
    parameter int DATA_W       = 10,
    parameter int DEPTH        = 600,
    parameter int ADDR_W       = 10,
    parameter int CH_W         = 1,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                     CLK100MHz,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    input  logic [CH_W-1:0]          trig_src,
    input  logic [DATA_W-1:0]        trig_level,
    input  logic                     trig_slope,
    input  logic [1:0]               trig_mode,
    input  logic [ADDR_W-1:0]        pretrig,
    input  logic                     arm,
    input  logic                     frame_ack,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     busy,
    output logic                     frame_ready,
    output logic                     forced
);
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [TO_W-1:0]   TO_LIM  = TO_W'(AUTO_TIMEOUT);

    typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;

    state_t                   state_q;
    logic [NUM_CH*DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, trig_ptr_q, pre_q, cnt_q;
    logic [ADDR_W:0]   post_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [CH_W-1:0]   src_q;
    logic [DATA_W-1:0] level_q, prev_q;
    logic              slope_q, auto_q, prev_valid_q;
    logic              busy_q, ready_q, forced_q;

    logic [NUM_CH*DATA_W-1:0] rd_word_q;
    logic [CH_W-1:0]          rd_ch_q;
    logic                     rd_oob_q;

    logic [ADDR_W-1:0] pre_d, wr_ptr_d, phys_d;
    logic [CH_W-1:0]   src_d;
    logic [ADDR_W:0]   post_len, base, sum;
    logic [DATA_W-1:0] src_smp;
    logic              wr_en, rise_hit, fall_hit, hit, timeout, rd_oob_d;

    // Out-of-range configuration is clamped as it is latched
    assign pre_d = ({1'b0, pretrig} >= DEPTH_X) ? LAST : pretrig;
    assign src_d = (int'(trig_src) >= NUM_CH) ? '0 : trig_src;

    assign src_smp  = sample_data[src_q*DATA_W +: DATA_W];
    assign rise_hit = prev_valid_q && (prev_q < level_q) && (src_smp >= level_q);
    assign fall_hit = prev_valid_q && (prev_q > level_q) && (src_smp <= level_q);
    assign hit      = slope_q ? fall_hit : rise_hit;
    assign timeout  = auto_q && (to_cnt_q + TO_W'(1) == TO_LIM);
    assign post_len = DEPTH_X - {1'b0, pre_q};

    assign wr_en = sample_valid &&
                   (state_q == PRE || state_q == WAIT_TRIG || state_q == POST);
    assign wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + ADDR_W'(1);

    always_ff @(posedge CLK100MHz or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            trig_ptr_q   <= '0;
            pre_q        <= '0;
            cnt_q        <= '0;
            post_cnt_q   <= '0;
            to_cnt_q     <= '0;
            src_q        <= '0;
            level_q      <= '0;
            prev_q       <= '0;
            slope_q      <= 1'b0;
            auto_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            forced_q     <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_d;
            unique case (state_q)
                IDLE: begin
                    if (trig_mode != 2'b10 || arm) begin
                        pre_q        <= pre_d;
                        src_q        <= src_d;
                        level_q      <= trig_level;
                        slope_q      <= trig_slope;
                        auto_q       <= (trig_mode == 2'b00);
                        cnt_q        <= '0;
                        to_cnt_q     <= '0;
                        prev_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= (pre_d == '0) ? WAIT_TRIG : PRE;
                    end
                end
                PRE: begin
                    if (sample_valid) begin
                        cnt_q        <= cnt_q + ADDR_W'(1);
                        prev_q       <= src_smp;
                        prev_valid_q <= 1'b1;
                        if (cnt_q + ADDR_W'(1) == pre_q)
                            state_q <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (sample_valid) begin
                        prev_q       <= src_smp;
                        prev_valid_q <= 1'b1;
                        if (auto_q)
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        if (hit || timeout) begin
                            trig_ptr_q <= wr_ptr_q;
                            post_cnt_q <= (ADDR_W+1)'(1);
                            forced_q   <= !hit;
                            // Maximum pretrig leaves room only for the trigger sample
                            if (pre_q == LAST) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                            end else begin
                                state_q <= POST;
                            end
                        end
                    end
                end
                POST: begin
                    if (sample_valid) begin
                        post_cnt_q <= post_cnt_q + (ADDR_W+1)'(1);
                        if (post_cnt_q + (ADDR_W+1)'(1) == post_len) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (frame_ack) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (wr_en)
            mem[wr_ptr_q] <= sample_data;
    end

    assign base = (trig_ptr_q >= pre_q)
                ? {1'b0, trig_ptr_q} - {1'b0, pre_q}
                : {1'b0, trig_ptr_q} + DEPTH_X - {1'b0, pre_q};
    assign sum      = base + {1'b0, rd_addr};
    assign phys_d   = ADDR_W'((sum >= DEPTH_X) ? sum - DEPTH_X : sum);
    assign rd_oob_d = ({1'b0, rd_addr} >= DEPTH_X) || (int'(rd_ch) >= NUM_CH);

    always_ff @(posedge CLK100MHz) begin
        if (ready_q)
            rd_word_q <= mem[phys_d];
    end

    // rd_oob_q resets high so rd_data reads 0 before any frame
    always_ff @(posedge CLK100MHz or posedge rst) begin
        if (rst) begin
            rd_ch_q  <= '0;
            rd_oob_q <= 1'b1;
        end else if (ready_q) begin
            rd_ch_q  <= rd_ch;
            rd_oob_q <= rd_oob_d;
        end
    end

    assign rd_data     = rd_oob_q ? '0 : rd_word_q[rd_ch_q*DATA_W +: DATA_W];
    assign busy        = busy_q;
    assign frame_ready = ready_q;
    assign forced      = forced_q;

endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: table-driven frame captures with a readout scoreboard,
// plus hand sequences for single-mode arming and reset during POST.
module tb_scope_capture;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 10;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 5;
    localparam int CH_W   = 1;
    localparam int ATO    = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     sample_valid;
    logic [NUM_CH*DATA_W-1:0] sample_data;
    logic [CH_W-1:0]          trig_src;
    logic [DATA_W-1:0]        trig_level;
    logic                     trig_slope;
    logic [1:0]               trig_mode;
    logic [ADDR_W-1:0]        pretrig;
    logic                     arm;
    logic                     frame_ack;
    logic [CH_W-1:0]          rd_ch;
    logic [ADDR_W-1:0]        rd_addr;
    logic [DATA_W-1:0]        rd_data;
    logic                     busy;
    logic                     frame_ready;
    logic                     forced;

    scope_capture #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .ADDR_W(ADDR_W), .CH_W(CH_W), .AUTO_TIMEOUT(ATO)
    ) dut (
        .CLK100MHz(clk), .rst(rst),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .trig_src(trig_src), .trig_level(trig_level),
        .trig_slope(trig_slope), .trig_mode(trig_mode),
        .pretrig(pretrig), .arm(arm), .frame_ack(frame_ack),
        .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .frame_ready(frame_ready), .forced(forced)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        mode;
        logic              slope;
        logic [CH_W-1:0]   src;
        logic [DATA_W-1:0] level;
        logic [ADDR_W-1:0] pre;
        logic [ADDR_W-1:0] pre_mid;
        int                kind;
        int                gap;
        logic [CH_W-1:0]   rch;
        int                p_eff;
        int                trig_n;
        logic              forced;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int last_exp = 0;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int kind, input int ch, input int n);
        case (kind)
            0:       return (ch == 0) ? DATA_W'(10 * n) : DATA_W'(n);
            1:       return (ch == 0) ? DATA_W'(50) : DATA_W'(n);
            2:       return (ch == 0) ? DATA_W'(40 * n)
                                      : ((n < 9) ? DATA_W'(300) : DATA_W'(200));
            default: return (ch == 0) ? ((n == 1) ? DATA_W'(50) : DATA_W'(200))
                                      : DATA_W'(n);
        endcase
    endfunction

    task automatic drive(input int kind, input int n, input logic v);
        sample_valid = v;
        sample_data  = {pat(kind, 1, n), pat(kind, 0, n)};
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int  n;
        bit  got;
        int  a;
        int  e;
        trig_mode  = v.mode;
        trig_slope = v.slope;
        trig_src   = v.src;
        trig_level = v.level;
        pretrig    = v.pre;
        if (frame_ready) begin
            frame_ack = 1'b1;
            @(posedge clk); #1;
            frame_ack = 1'b0;
            chk({tag, " ack_drop"}, int'(frame_ready), 0);
        end
        if (v.mode == 2'b10) begin
            got = 0;
            for (int c = 0; c < 10; c++) begin
                drive(v.kind, c, 1'b1);
                @(posedge clk); #1;
                if (busy) got = 1;
            end
            sample_valid = 1'b0;
            chk({tag, " noarm_busy"}, int'(got), 0);
            arm = 1'b1;
            @(posedge clk); #1;
            arm = 1'b0;
        end
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (busy) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, " busy_start"}, int'(got), 1);
        if (!got) return;
        n = 0;
        got = 0;
        for (int c = 0; c < 200; c++) begin
            if (frame_ready) begin
                got = 1;
                break;
            end
            if (n == 5) pretrig = v.pre_mid;
            drive(v.kind, n, (v.gap == 0) || (c % 2 == 0));
            @(posedge clk); #1;
            if (sample_valid) n++;
        end
        sample_valid = 1'b0;
        chk({tag, " frame_ready"}, int'(got), 1);
        if (!got) return;
        chk({tag, " samples_to_ready"}, n, v.trig_n + DEPTH - v.p_eff);
        chk({tag, " forced"}, int'(forced), int'(v.forced));
        chk({tag, " busy_done"}, int'(busy), 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            a = (i < 2) ? (DEPTH + i * 15) : (i - 2);
            rd_ch   = v.rch;
            rd_addr = ADDR_W'(a);
            if (a < DEPTH)
                exp_q.push_back(int'(pat(v.kind, int'(v.rch), v.trig_n - v.p_eff + a)));
            else
                exp_q.push_back(0);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            last_exp = e;
            chk($sformatf("%s rd[%0d]", tag, a), int'(rd_data), e);
        end
    endtask

    vec_t vecs[8];
    vec_t vauto;
    bit   seen;

    initial begin
        vecs[0] = '{2'b01, 1'b0, 1'b0, 10'd100, 5'd4,  5'd4,  0, 0, 1'b0, 4,  10, 1'b0};
        vecs[1] = '{2'b00, 1'b0, 1'b0, 10'd100, 5'd4,  5'd4,  1, 0, 1'b1, 4,  11, 1'b1};
        vecs[2] = '{2'b01, 1'b1, 1'b1, 10'd250, 5'd4,  5'd4,  2, 0, 1'b1, 4,  9,  1'b0};
        vecs[3] = '{2'b01, 1'b0, 1'b0, 10'd100, 5'd4,  5'd10, 0, 1, 1'b0, 4,  10, 1'b0};
        vecs[4] = '{2'b01, 1'b0, 1'b0, 10'd200, 5'd20, 5'd20, 0, 0, 1'b1, 15, 20, 1'b0};
        vecs[5] = '{2'b01, 1'b0, 1'b0, 10'd35,  5'd4,  5'd4,  0, 0, 1'b0, 4,  4,  1'b0};
        vecs[6] = '{2'b11, 1'b0, 1'b0, 10'd100, 5'd0,  5'd0,  3, 0, 1'b1, 0,  2,  1'b0};
        vecs[7] = '{2'b10, 1'b0, 1'b0, 10'd100, 5'd4,  5'd4,  0, 0, 1'b0, 4,  10, 1'b0};
        vauto   = '{2'b00, 1'b0, 1'b0, 10'd100, 5'd4,  5'd4,  0, 0, 1'b0, 4,  10, 1'b0};

        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        trig_src     = '0;
        trig_level   = '0;
        trig_slope   = 1'b0;
        trig_mode    = 2'b10;
        pretrig      = '0;
        arm          = 1'b0;
        frame_ack    = 1'b0;
        rd_ch        = '0;
        rd_addr      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset frame_ready", int'(frame_ready), 0);
        chk("reset forced", int'(forced), 0);
        chk("reset rd_data", int'(rd_data), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_frame(vecs[i], $sformatf("vec%0d", i));

        // Single mode: after ack, no capture without another arm; readout holds
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
        chk("single ack_drop", int'(frame_ready), 0);
        rd_addr = '0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            drive(0, c, 1'b1);
            @(posedge clk); #1;
            if (busy || frame_ready) seen = 1;
        end
        sample_valid = 1'b0;
        chk("single no_recapture", int'(seen), 0);
        chk("rd_data hold", int'(rd_data), last_exp);

        // Reset asserted while in POST
        trig_mode  = 2'b01;
        trig_slope = 1'b0;
        trig_src   = '0;
        trig_level = 10'd100;
        pretrig    = 5'd4;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (busy) seen = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rst_seq busy_start", int'(seen), 1);
        for (int n = 0; n < 14; n++) begin
            drive(0, n, 1'b1);
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        chk("rst_seq in_post busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_seq busy", int'(busy), 0);
        chk("rst_seq frame_ready", int'(frame_ready), 0);
        trig_mode = 2'b10;
        @(posedge clk); #1;
        chk("rst_seq held busy", int'(busy), 0);
        rst = 1'b0;

        for (int f = 0; f < 3; f++)
            run_frame(vauto, $sformatf("auto%0d", f));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
